// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: initial whitening, nine full rounds,
// one final round without MixColumns, with on-the-fly key expansion.
module aes128_encrypt_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         ready,
   output logic         done,
   output logic [127:0] data_out
);

   if (NR != 10) begin : g_bad_nr
      $error("aes128_encrypt_ctrl supports only NR = 10");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [127:0] state_q, key_q, out_q;
   logic [3:0]   rnd_q;
   logic [7:0]   rcon_q;

   // ---------------------------------------------------------------- GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r, base, e, b;
      r    = 8'h01;
      base = x;
      e    = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // ---------------------------------------------------------------- round steps
   // Byte i of a block sits at [127-8*i -: 8]; byte i is row i%4, column i/4.
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int row = 0; row < 4; row++)
         for (int col = 0; col < 4; col++)
            r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      for (int col = 0; col < 4; col++) begin
         a0 = s[127-32*col -: 8];
         a1 = s[119-32*col -: 8];
         a2 = s[111-32*col -: 8];
         a3 = s[103-32*col -: 8];
         r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, rot, sw;
      w0  = k[127:96];
      w1  = k[95:64];
      w2  = k[63:32];
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      sw  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      w0  = w0 ^ sw ^ {rcon, 24'h0};
      w1  = w1 ^ w0;
      w2  = w2 ^ w1;
      w3  = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // ---------------------------------------------------------------- datapath
   logic [127:0] next_key, shifted, round_val, final_val;

   assign next_key  = expand(key_q, rcon_q);
   assign shifted   = shift_rows(sub_bytes(state_q));
   assign round_val = mix_columns(shifted) ^ next_key;
   assign final_val = shifted ^ next_key;

   // NOTE: state is updated with non-blocking assignments so every register in
   // this block samples the pre-edge values of the others, as real flops do.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         key_q   <= '0;
         out_q   <= '0;
         rnd_q   <= 4'd0;
         rcon_q  <= 8'h01;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  state_q <= data_in ^ key_in;
                  key_q   <= key_in;
                  rnd_q   <= 4'd1;
                  rcon_q  <= 8'h01;
               end
            end
            ROUND: begin
               key_q  <= next_key;
               rnd_q  <= rnd_q + 4'd1;
               rcon_q <= xtime(rcon_q);
               if (rnd_q == LAST_RND) begin
                  state_q <= final_val;
                  out_q   <= final_val;
               end else begin
                  state_q <= round_val;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      fsm_d = fsm_q;
      ready = 1'b0;
      done  = 1'b0;
      case (fsm_q)
         IDLE: begin
            ready = 1'b1;
            if (start) fsm_d = ROUND;
         end
         ROUND: begin
            if (rnd_q == LAST_RND) fsm_d = DONE;
         end
         DONE: begin
            done  = 1'b1;
            fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   assign data_out = out_q;

endmodule
